// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and field-packing helpers shared by the instruction encoder and decoder.
package rv_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLTIU, OP_SLTI, OP_SLLI, OP_SRLI,
    OP_SRAI, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_SLL, OP_SRL,
    OP_SRA, OP_SLTU, OP_SLT, OP_SW, OP_BNE, OP_BEQ, OP_BLT, OP_BGE,
    OP_BLTU, OP_BGEU, OP_JALR, OP_JAL
  } op_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] op_funct3(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_ADD, OP_SUB:  return F3_ADD;
      OP_SLLI, OP_SLL:          return F3_SLL;
      OP_SLTI, OP_SLT:          return F3_SLT;
      OP_SLTIU, OP_SLTU:        return F3_SLTU;
      OP_XORI, OP_XOR:          return F3_XOR;
      OP_SRLI, OP_SRAI, OP_SRL, OP_SRA: return F3_SR;
      OP_ORI, OP_OR:            return F3_OR;
      OP_ANDI, OP_AND:          return F3_AND;
      OP_SW:                    return F3_SW;
      OP_BEQ:                   return F3_BEQ;
      OP_BNE:                   return F3_BNE;
      OP_BLT:                   return F3_BLT;
      OP_BGE:                   return F3_BGE;
      OP_BLTU:                  return F3_BLTU;
      OP_BGEU:                  return F3_BGEU;
      default:                  return F3_JALR;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  // Branch and jump offsets are always even, so bit 0 is never passed in.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/rv_word_pack.sv
// Combinational packing of one symbolic operation into an RV32I word plus a legality flag.
module rv_word_pack
  import rv_isa_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [20:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic       w_fits12;
  logic       w_fits13;
  logic       w_shamt_ok;
  logic       w_even;
  logic [2:0] w_f3;

  // A signed value fits N bits when every bit above N-2 equals the sign.
  assign w_fits12   = (&i_imm[20:11]) | ~(|i_imm[20:11]);
  assign w_fits13   = (&i_imm[20:12]) | ~(|i_imm[20:12]);
  assign w_shamt_ok = ~(|i_imm[20:5]);
  assign w_even     = ~i_imm[0];
  assign w_f3       = op_funct3(i_op);

  always_comb begin
    o_word  = '0;
    o_legal = 1'b0;
    case (i_op)
      OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLTIU, OP_SLTI, OP_JALR: begin
        o_word  = enc_i(i_imm[11:0], i_rs1, w_f3, i_rd,
                        (i_op == OP_JALR) ? OPC_JALR : OPC_OPIMM);
        o_legal = w_fits12;
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        o_word  = enc_r((i_op == OP_SRAI) ? F7_ALT : F7_BASE, i_imm[4:0], i_rs1, w_f3,
                        i_rd, OPC_OPIMM);
        o_legal = w_shamt_ok;
      end
      OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLTU, OP_SLT: begin
        o_word  = enc_r((i_op == OP_SUB || i_op == OP_SRA) ? F7_ALT : F7_BASE, i_rs2, i_rs1,
                        w_f3, i_rd, OPC_OP);
        o_legal = 1'b1;
      end
      OP_SW: begin
        o_word  = enc_s(i_imm[11:0], i_rs2, i_rs1, w_f3);
        o_legal = w_fits12;
      end
      OP_BNE, OP_BEQ, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        o_word  = enc_b(i_imm[12:1], i_rs2, i_rs1, w_f3);
        o_legal = w_fits13 & w_even;
      end
      OP_JAL: begin
        o_word  = enc_j(i_imm[20:1], i_rd);
        o_legal = w_even;
      end
      default: begin
        o_word  = '0;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words with auto-incrementing byte addresses; illegal requests are counted and dropped.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERRW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [20:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [31:0]     out_addr,
  output logic            err,
  output logic [4:0]      err_op,
  output logic [ERRW-1:0] err_cnt
);

  logic            r_out_valid;
  logic [31:0]     r_out_data;
  logic [31:0]     r_out_addr;
  logic [31:0]     r_next_addr;
  logic            r_err;
  logic [4:0]      r_err_op;
  logic [ERRW-1:0] r_err_cnt;

  logic [31:0]     w_word;
  logic            w_legal;
  logic            w_accept;
  logic [31:0]     w_word_addr;
  logic [ERRW-1:0] w_cnt_next;

  rv_word_pack u_pack (
    .i_op   (in_op),
    .i_rd   (in_rd),
    .i_rs1  (in_rs1),
    .i_rs2  (in_rs2),
    .i_imm  (in_imm),
    .o_word (w_word),
    .o_legal(w_legal)
  );

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  // clr in the same cycle restarts numbering at this very word, and a reject then counts as the first.
  assign w_word_addr = clr ? BASE_ADDR : r_next_addr;
  assign w_cnt_next  = clr ? ERRW'(1) : ((&r_err_cnt) ? r_err_cnt : r_err_cnt + ERRW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= BASE_ADDR;
      r_next_addr <= BASE_ADDR;
      r_err       <= 1'b0;
      r_err_op    <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (clr) begin
        r_next_addr <= BASE_ADDR;
        r_err       <= 1'b0;
        r_err_op    <= '0;
        r_err_cnt   <= '0;
      end
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_addr  <= w_word_addr;
        r_next_addr <= w_word_addr + 32'd4;
      end
      if (w_accept && !w_legal) begin
        r_err     <= 1'b1;
        r_err_op  <= in_op;
        r_err_cnt <= w_cnt_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign err       = r_err;
  assign err_op    = r_err_op;
  assign err_cnt   = r_err_cnt;

endmodule
